rope_electro_scheduler: RTL and testbench
=========================================

# rope_electro_scheduler

Sequences the electrification of the jungle ropes. One rope at a time runs through a warning phase, a live phase and a gap phase. Frame pacing comes from `startOfFrame`. The block drives the per-rope `electroStatus` bus consumed by the rope display and reports shocks when the monkey touches a live rope. It sits between the game-control logic and the rope display array.

## Interface
Parameters:
- `ROPES`, 6: number of ropes; range 2..8.
- `WARN_FRAMES`, 30: frames in the WARN phase; range 1..256.
- `LIVE_FRAMES`, 60: frames in the LIVE phase; range 1..256.
- `GAP_FRAMES`, 45: frames in the GAP phase; range 1..256.

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  synchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `enable`  in  1  1 = run, 0 = pause (all state frozen).
- `monkeyCollision`  in  ROPES  per-rope collision with the monkey, level.
- `electroStatus`  out  ROPES x 2  per-rope status: 00 off, 01 warning, 10 live; 11 is never driven.
- `activeRope`  out  $clog2(ROPES)  index of the rope currently being sequenced.
- `phase`  out  2  00 GAP, 01 WARN, 10 LIVE.
- `shockPulse`  out  1  one-cycle pulse on a shock event.

## Operation
- FSM states are GAP, WARN and LIVE.
- Each state owns an 8-bit frame counter `frameCnt`, loaded with (duration-1) on state entry.
- On a `startOfFrame` cycle with `enable`=1:
  - if `frameCnt`==0, transition to the next state and reload the counter;
  - otherwise decrement `frameCnt`.
- Each state therefore lasts exactly its duration in `startOfFrame` pulses.
- Transitions:
  - GAP -> WARN: `activeRope` advances to (`activeRope`+1), wrapping ROPES-1 -> 0.
  - WARN -> LIVE.
  - LIVE -> GAP.
- `electroStatus[activeRope]` is 01 in WARN and 10 in LIVE. All other ropes, and all ropes in GAP, are 00.
- Shock detection:
  - `monkeyCollision` is registered once (`prevCol`).
  - A shock occurs in LIVE with `enable`=1 when `monkeyCollision[activeRope]`=1 and `prevCol[activeRope]`=0 (rising edge).
  - On a shock, `shockPulse` is 1 for one cycle and the FSM goes to GAP at once, reloading `frameCnt` to GAP_FRAMES-1. The rope discharges.
- Simultaneous events:
  - Shock and LIVE expiry in the same cycle: one `shockPulse`, one transition to GAP.
  - A collision held high into a new LIVE phase does not shock until it falls and rises again. This holds only because `prevCol` is tracked continuously.
- Collisions on non-active ropes, or in WARN/GAP, are ignored.
- `enable`=0: counters, state, pointer and outputs are held and `shockPulse` is forced to 0. `prevCol` continues to track.
- Reset values, applied on the clock edge with `resetN`=0:
  - state GAP, `frameCnt`=GAP_FRAMES-1, `activeRope`=ROPES-1;
  - `electroStatus` all 00, `phase`=00, `shockPulse`=0, `prevCol`=0.
  - The first rope energized after reset is therefore rope 0.
- Reset mid-phase aborts immediately to the reset state. No partial status is kept.

## Timing
- All outputs are registered.
- State, `activeRope`, `phase` and `electroStatus` update on the edge that samples the qualifying `startOfFrame` pulse. They are visible the following cycle.
- `shockPulse` asserts the cycle after the sampled collision edge. The status of the shocked rope drops to 00 in that same cycle.
- `startOfFrame` coinciding with a shock: the shock wins. The counter loads GAP_FRAMES-1 and does not decrement.
- The WARN phase of the next rope starts exactly GAP_FRAMES frames after LIVE ends or after a shock.

## Configuration
- `ROPE_SCHED_RANDOM_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) steps on every `startOfFrame` while `enable`=1.
  - At GAP -> WARN the next rope is (lfsr mod ROPES). If that equals the current `activeRope`, (current+1) wrapped is used instead, so no rope repeats back to back.
  - The first rope after reset is still rope 0.
- `ROPE_SCHED_RANDOM_EN` undefined: strict round-robin as described above. No LFSR logic.

## Test plan
- Reset, then `enable`=1 with continuous frames, using WARN=2, LIVE=3, GAP=2 -> rope 0 status is 00 for 2 frames, 01 for 2, 10 for 3; then rope 1 follows. After rope 5 the sequence wraps to rope 0.
- During LIVE on rope 2, a rising edge on `monkeyCollision[2]` -> `shockPulse` for one cycle next cycle, `electroStatus[2]`=00, `phase`=GAP with a full GAP_FRAMES count.
- `monkeyCollision[2]` held high from WARN into LIVE -> no shock. A drop followed by a rise during LIVE -> exactly one shock.
- A collision rising on rope 3 in the same cycle as the final LIVE `startOfFrame` of rope 3 -> a single `shockPulse` and a single GAP entry.
- `enable`=0 for 10 frames mid-WARN -> status, `phase` and count are frozen. After `enable` returns to 1 the remaining WARN frames complete exactly. `resetN`=0 mid-LIVE -> all status 00 and GAP on the next cycle.
- `ROPE_SCHED_RANDOM_EN` defined, 200 rope cycles -> never the same rope twice in a row, all indices < ROPES, first rope 0.

Source files
------------

// File: rtl/rope_electro_scheduler.sv
// Rope electrification sequencer: GAP -> WARN -> LIVE per rope, paced by startOfFrame.
// Define ROPE_SCHED_RANDOM_EN for LFSR-based rope selection instead of round-robin.
module rope_electro_scheduler #(
  parameter int unsigned ROPES       = 6,
  parameter int unsigned WARN_FRAMES = 30,
  parameter int unsigned LIVE_FRAMES = 60,
  parameter int unsigned GAP_FRAMES  = 45
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       enable,
  input  logic [ROPES-1:0]           monkeyCollision,
  output logic [2*ROPES-1:0]         electroStatus,
  output logic [$clog2(ROPES)-1:0]   activeRope,
  output logic [1:0]                 phase,
  output logic                       shockPulse
);

  localparam int unsigned RW = $clog2(ROPES);
  localparam logic [7:0] WarnLoad = 8'(WARN_FRAMES - 1);
  localparam logic [7:0] LiveLoad = 8'(LIVE_FRAMES - 1);
  localparam logic [7:0] GapLoad  = 8'(GAP_FRAMES - 1);

  typedef enum logic [1:0] {
    StGap  = 2'b00,
    StWarn = 2'b01,
    StLive = 2'b10
  } state_e;

  state_e               state_q;
  logic [7:0]           frame_cnt_q;
  logic [RW-1:0]        active_q;
  logic [ROPES-1:0]     prev_col_q;
  logic [2*ROPES-1:0]   status_q;
  logic [1:0]           phase_q;
  logic                 shock_q;

  logic                 tick;
  logic                 shock;
  logic                 gap_to_warn;
  logic [RW-1:0]        rope_rr;
  logic [RW-1:0]        rope_next;
  logic [2*ROPES-1:0]   warn_vec;
  logic [2*ROPES-1:0]   live_vec;

  always_comb begin
    tick        = enable & startOfFrame;
    shock       = enable && (state_q == StLive) &&
                  monkeyCollision[active_q] && !prev_col_q[active_q];
    gap_to_warn = !shock && tick && (frame_cnt_q == 8'd0) && (state_q == StGap);
    rope_rr     = (active_q == RW'(ROPES - 1)) ? '0 : active_q + RW'(1);
  end

`ifdef ROPE_SCHED_RANDOM_EN
  logic [7:0]    lfsr_q;
  logic          first_q;
  logic [RW-1:0] rope_pick;

  always_comb begin
    rope_pick = RW'(lfsr_q % 8'(ROPES));
    if (first_q) begin
      rope_next = '0;
    end else if (rope_pick == active_q) begin
      rope_next = rope_rr;
    end else begin
      rope_next = rope_pick;
    end
  end

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk) begin
    if (!resetN) begin
      lfsr_q  <= 8'hA5;
      first_q <= 1'b1;
    end else begin
      if (tick) begin
        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
      if (gap_to_warn) begin
        first_q <= 1'b0;
      end
    end
  end
`else
  assign rope_next = rope_rr;
`endif

  always_comb begin
    warn_vec = '0;
    live_vec = '0;
    for (int unsigned i = 0; i < ROPES; i++) begin
      if (rope_next == RW'(i)) warn_vec[2*i +: 2] = 2'b01;
      if (active_q == RW'(i))  live_vec[2*i +: 2] = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= StGap;
      frame_cnt_q <= GapLoad;
      active_q    <= RW'(ROPES - 1);
      prev_col_q  <= '0;
      status_q    <= '0;
      phase_q     <= 2'b00;
      shock_q     <= 1'b0;
    end else begin
      // prevCol tracks even while paused so a held collision never re-triggers
      prev_col_q <= monkeyCollision;
      shock_q    <= shock;
      if (shock) begin
        state_q     <= StGap;
        frame_cnt_q <= GapLoad;
        status_q    <= '0;
        phase_q     <= 2'b00;
      end else if (tick) begin
        if (frame_cnt_q == 8'd0) begin
          unique case (state_q)
            StGap: begin
              state_q     <= StWarn;
              frame_cnt_q <= WarnLoad;
              active_q    <= rope_next;
              status_q    <= warn_vec;
              phase_q     <= 2'b01;
            end
            StWarn: begin
              state_q     <= StLive;
              frame_cnt_q <= LiveLoad;
              status_q    <= live_vec;
              phase_q     <= 2'b10;
            end
            default: begin
              state_q     <= StGap;
              frame_cnt_q <= GapLoad;
              status_q    <= '0;
              phase_q     <= 2'b00;
            end
          endcase
        end else begin
          frame_cnt_q <= frame_cnt_q - 8'd1;
        end
      end
    end
  end

  assign electroStatus = status_q;
  assign activeRope    = active_q;
  assign phase         = phase_q;
  assign shockPulse    = shock_q;

endmodule

// File: tb/tb_rope_electro_scheduler.sv
// Randomized scoreboard bench for rope_electro_scheduler against a frames-remaining model.
module tb_rope_electro_scheduler;

  localparam int unsigned R  = 6;
  localparam int unsigned W  = 2;
  localparam int unsigned L  = 3;
  localparam int unsigned G  = 2;
  localparam int unsigned RW = 3;
  localparam int          EW = 2 * R + RW + 3;

  logic            clk = 1'b0;
  logic            resetN;
  logic            startOfFrame;
  logic            enable;
  logic [R-1:0]    monkeyCollision;
  logic [2*R-1:0]  electroStatus;
  logic [RW-1:0]   activeRope;
  logic [1:0]      phase;
  logic            shockPulse;

  always #5 clk = ~clk;

  rope_electro_scheduler #(
    .ROPES      (R),
    .WARN_FRAMES(W),
    .LIVE_FRAMES(L),
    .GAP_FRAMES (G)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .enable         (enable),
    .monkeyCollision(monkeyCollision),
    .electroStatus  (electroStatus),
    .activeRope     (activeRope),
    .phase          (phase),
    .shockPulse     (shockPulse)
  );

  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0=GAP 1=WARN 2=LIVE, frames left in the current phase, rope index
  int         m_ph;
  int         m_left;
  int         m_rope;
  logic [R-1:0] m_prev;
  logic       m_shock;
  logic [7:0] m_lfsr;
  bit         m_first;

  function automatic logic [EW-1:0] model_out();
    logic [2*R-1:0] st;
    st = '0;
    if (m_ph == 1) st[2*m_rope +: 2] = 2'b01;
    if (m_ph == 2) st[2*m_rope +: 2] = 2'b10;
    return {st, RW'(m_rope), 2'(m_ph), m_shock};
  endfunction

  function automatic int next_rope();
`ifdef ROPE_SCHED_RANDOM_EN
    int p;
    if (m_first) begin
      m_first = 0;
      return 0;
    end
    p = int'(m_lfsr) % R;
    if (p == m_rope) p = (m_rope + 1) % R;
    return p;
`else
    return (m_rope + 1) % R;
`endif
  endfunction

  task automatic model_step();
    if (!resetN) begin
      m_ph    = 0;
      m_left  = G;
      m_rope  = R - 1;
      m_prev  = '0;
      m_shock = 1'b0;
      m_lfsr  = 8'hA5;
      m_first = 1;
    end else begin
      m_shock = enable && m_ph == 2 && monkeyCollision[m_rope] && !m_prev[m_rope];
      m_prev  = monkeyCollision;
      if (m_shock) begin
        m_ph   = 0;
        m_left = G;
      end else if (enable && startOfFrame) begin
        m_left--;
        if (m_left == 0) begin
          case (m_ph)
            0: begin m_rope = next_rope(); m_ph = 1; m_left = W; end
            1: begin m_ph = 2; m_left = L; end
            default: begin m_ph = 0; m_left = G; end
          endcase
        end
      end
      if (enable && startOfFrame)
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask

  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_got;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {electroStatus, activeRope, phase, shockPulse};
      n_tests++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL outputs @%0t: got status=%h rope=%0d phase=%0d shock=%b, expected status=%h rope=%0d phase=%0d shock=%b",
                 $time, mon_got[EW-1 -: 2*R], mon_got[RW+2:3], mon_got[2:1], mon_got[0],
                 mon_exp[EW-1 -: 2*R], mon_exp[RW+2:3], mon_exp[2:1], mon_exp[0]);
      end
    end
  end

  initial begin
    resetN          = 1'b0;
    startOfFrame    = 1'b0;
    enable          = 1'b0;
    monkeyCollision = '0;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #2;
      resetN       = (cyc < 3) ? 1'b0 : ($urandom_range(0, 499) != 0);
      startOfFrame = ($urandom_range(0, 2) == 0);
      if (cyc >= 1000 && cyc < 1040) enable = 1'b0;
      else enable = ($urandom_range(0, 9) != 0);
      // Clean collision-free run first so the plain rope sequence is exercised
      if (cyc >= 300) begin
        for (int b = 0; b < R; b++)
          if ($urandom_range(0, 5) == 0) monkeyCollision[b] = ~monkeyCollision[b];
      end
      model_step();
      exp_q.push_back(model_out());
    end
    @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
